// File: rtl/spi_pixel_loader.sv
// SPI mode-0 slave that streams one frame of pixel bytes into the image RAM.
// SPI pins are oversampled on clk; a finished frame is held until frame_ack.
//
//  state | meaning
//  IDLE  | waiting for a CS falling edge to start a frame at address 0
//  RECV  | receiving bytes; CS may rise and fall again without losing the address
//  DONE  | full frame written, load_done high, waiting for frame_ack
module spi_pixel_loader #(
   parameter int IMAGE_SIZE       = 4096,
   parameter int IMAGE_ADDR_WIDTH = 12,
   parameter int RGB_SIZE         = 8,
   parameter int SYNC_STAGES      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        spi_clk,
   input  logic                        spi_mosi,
   input  logic                        spi_cs,
   output logic                        spi_miso,
   output logic                        ram_we,
   output logic [IMAGE_ADDR_WIDTH-1:0] ram_addr,
   output logic [RGB_SIZE-1:0]         ram_wdata,
   output logic                        load_done,
   input  logic                        frame_ack,
   output logic [RGB_SIZE-1:0]         first_byte,
   output logic [RGB_SIZE-1:0]         last_byte
);

   localparam int BIT_W = $clog2(RGB_SIZE);
   localparam logic [BIT_W-1:0]            LAST_BIT  = BIT_W'(RGB_SIZE - 1);
   localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0]      sclk_sync, mosi_sync, cs_sync;
   logic                        sclk_prev, cs_prev;
   logic                        sclk_s, mosi_s, cs_s;
   logic                        sclk_rise, sclk_fall, cs_fall, cs_low;
   logic                        byte_done;
   logic [BIT_W-1:0]            bit_cnt;
   logic [RGB_SIZE-1:0]         rx_shift, rx_byte;
   logic [RGB_SIZE-1:0]         tx_shift, echo_byte;
   logic [IMAGE_ADDR_WIDTH-1:0] wr_addr;

   // CS chain clears to 0 so a CS already low when reset releases never looks like a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         cs_prev   <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign cs_low    = ~cs_s;
   assign rx_byte   = {rx_shift[RGB_SIZE-2:0], mosi_s};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      byte_done = 1'b0;
      case (state_q)
         IDLE: if (cs_fall) state_d = RECV;
         RECV: begin
            byte_done = cs_low && !cs_fall && sclk_rise && (bit_cnt == LAST_BIT);
            if (byte_done && (wr_addr == LAST_ADDR)) state_d = DONE;
         end
         DONE: if (frame_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         load_done  <= 1'b0;
         first_byte <= '0;
         last_byte  <= '0;
         spi_miso   <= 1'b0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         echo_byte  <= '0;
         wr_addr    <= '0;
      end else begin
         ram_we    <= 1'b0;
         load_done <= (state_q == DONE) && (state_d == DONE);
         case (state_q)
            IDLE: begin
               spi_miso <= 1'b0;
               if (cs_fall) begin
                  wr_addr  <= '0;
                  bit_cnt  <= '0;
                  rx_shift <= '0;
                  spi_miso <= echo_byte[RGB_SIZE-1];
                  tx_shift <= {echo_byte[RGB_SIZE-2:0], 1'b0};
               end
            end
            RECV: begin
               if (cs_fall) begin
                  bit_cnt  <= '0;
                  spi_miso <= echo_byte[RGB_SIZE-1];
                  tx_shift <= {echo_byte[RGB_SIZE-2:0], 1'b0};
               end else if (!cs_low) begin
                  bit_cnt  <= '0;
                  rx_shift <= '0;
                  spi_miso <= 1'b0;
               end else begin
                  if (sclk_rise) begin
                     rx_shift <= rx_byte;
                     bit_cnt  <= bit_cnt + 1'b1;
                  end
                  if (byte_done) begin
                     bit_cnt   <= '0;
                     ram_we    <= 1'b1;
                     ram_addr  <= wr_addr;
                     ram_wdata <= rx_byte;
                     last_byte <= rx_byte;
                     echo_byte <= rx_byte;
                     if (wr_addr == '0)        first_byte <= rx_byte;
                     if (wr_addr != LAST_ADDR) wr_addr    <= wr_addr + 1'b1;
                  end
                  // A fall right after a completed byte starts the echo of that byte.
                  if (sclk_fall) begin
                     if (bit_cnt == '0) begin
                        spi_miso <= echo_byte[RGB_SIZE-1];
                        tx_shift <= {echo_byte[RGB_SIZE-2:0], 1'b0};
                     end else begin
                        spi_miso <= tx_shift[RGB_SIZE-1];
                        tx_shift <= {tx_shift[RGB_SIZE-2:0], 1'b0};
                     end
                  end
               end
            end
            DONE: spi_miso <= 1'b1;
            default: spi_miso <= 1'b0;
         endcase
      end
   end

endmodule

// File: doc/spi_pixel_loader.md
# spi_pixel_loader

SPI slave front end that receives a grayscale image from the Arduino master one byte per pixel and writes it into the image RAM ahead of `pixel_algorithm_unit`. It oversamples the SPI pins on the 50 MHz system clock and assembles mode-0 bytes. It issues single-cycle RAM writes at sequential addresses and signals frame completion to the dithering stage. A consumer handshake re-arms the loader for the next frame.

## Interface

- `IMAGE_SIZE`, 4096: pixels (bytes) per frame.
- `IMAGE_ADDR_WIDTH`, 12: RAM address width, equal to clog2(`IMAGE_SIZE`).
- `RGB_SIZE`, 8: bits per pixel; also the SPI word length.
- `SYNC_STAGES`, 2: flip-flop stages in the synchronizer on each SPI input.

- `clk`  in  1  system clock (`MAX10_CLK1_50`).
- `rst`  in  1  synchronous, active-high reset.
- `spi_clk`  in  1  SPI SCLK, asynchronous, CPOL=0.
- `spi_mosi`  in  1  SPI MOSI, asynchronous.
- `spi_cs`  in  1  SPI chip select, active low, asynchronous.
- `spi_miso`  out  1  SPI MISO.
- `ram_we`  out  1  RAM write strike, one cycle per byte.
- `ram_addr`  out  `IMAGE_ADDR_WIDTH`  write address.
- `ram_wdata`  out  `RGB_SIZE`  pixel byte.
- `load_done`  out  1  level signal; the full frame is in RAM.
- `frame_ack`  in  1  consumer has taken the frame; re-arm the loader.
- `first_byte`  out  8  byte written at address 0 of the current frame (debug).
- `last_byte`  out  8  most recently written byte (debug).

## Operation

- Each SPI input passes through `SYNC_STAGES` flops. Rise and fall detection of SCLK and CS uses the synchronized value and its previous value.
- States:
  - IDLE: a CS falling edge moves to RECV. Write address and bit counter are cleared.
  - RECV: while CS is low, each SCLK rising edge shifts MOSI into the shift register MSB-first and increments the 3-bit bit counter.
    - On the 8th bit, the assembled byte is written to the RAM.
    - After the write at address `IMAGE_SIZE-1`, the state moves to DONE.
    - Otherwise, the address increments by 1.
  - DONE: `load_done`=1. SCLK activity is ignored; no RAM writes occur. `frame_ack`=1 moves to IDLE and clears `load_done`.
- CS rising while in RECV:
  - The partial byte and the bit counter are discarded.
  - The address is retained, so the master may split a frame across several CS transactions.
  - The next CS fall resumes at the retained address.
- MISO, mode 0:
  - Shifts out the previously completed byte, MSB first, as an echo for loopback checking.
  - Bit 7 loads on CS fall. The next bit is driven after each synchronized SCLK falling edge.
  - Before any byte has been received, the echo byte is 0x00.
  - In DONE, MISO drives a constant 1.
  - While CS is high, MISO drives 0.
- `first_byte` updates only on the write at address 0. `last_byte` updates on every write.
- The address never wraps; reaching DONE is the only terminal condition.
- `frame_ack` outside DONE is ignored, including when it is asserted in the same cycle as the final write.
- `rst` at any time, including mid-byte or mid-frame:
  - The state returns to IDLE.
  - All counters, the shift register and the echo byte clear.
  - After `rst` deasserts, a CS that is already low does not start a frame. The loader waits for a fresh CS falling edge.

## Timing

- Reset values: `spi_miso`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `load_done`=0, `first_byte`=0, `last_byte`=0.
- Edge detection latency: an SPI pin edge is detected `SYNC_STAGES`+1 `clk` cycles after it arrives.
- The SCLK period must be at least 8 `clk` cycles, with high and low phases of at least 3 cycles each. Slower SCLK is always legal.
- Write timing:
  - `ram_we` pulses exactly 1 cycle, registered, in the cycle after the 8th detected rising edge.
  - `ram_addr` and `ram_wdata` are valid in that same cycle.
- `load_done` rises in the cycle after the final `ram_we`.
- `frame_ack` sampled high in DONE makes `load_done`=0 in the following cycle.
- MISO output changes at most 1 cycle after a detected SCLK fall. This guarantees setup time before the next SCLK rise at the minimum SCLK period.

## Test plan

- Reset/idle:
  - Stimulus: `rst` held 3 cycles, no SPI activity.
  - Required: all outputs are 0 and `ram_we` never pulses.
- Single byte:
  - Stimulus: CS low, send 0xA5 with SCLK = `clk`/10.
  - Required:
    - One `ram_we` pulse with addr 0 and data 0xA5.
    - `first_byte`=`last_byte`=0xA5.
    - `spi_miso` shifts 0x00 during that byte.
- Full frame:
  - Stimulus: send bytes `i` mod 256 for i=0..4095, then `frame_ack`.
  - Required:
    - 4096 writes, each with addr=i and data=`i` mod 256.
    - `load_done` rises one cycle after the write at 4095.
    - A 4097th byte produces no write.
    - After the ack, `load_done`=0 and the state is IDLE.
- Split transaction:
  - Stimulus: send 3 bytes, raise CS after 4 bits of the 4th byte, lower CS, then send 0x3C.
  - Required: 0x3C is written at addr 3; the partial bits are discarded.
- Echo:
  - Stimulus: send 0x12 then 0x34.
  - Required: MISO carries 0x12, MSB first, during the second byte.
- Reset mid-frame and early ack:
  - Stimulus: send 10 bytes, then assert `rst`, then start a new frame. Separately, pulse `frame_ack` while in RECV.
  - Required:
    - After `rst`, the next write is at addr 0.
    - `frame_ack` in RECV has no effect.
